// File: rtl/and_pkg.sv
// -----------------------------------------------------------------------------
// and_pkg
// Shared helpers for the pipelined AND/NAND reduction tree.
//   clog2(n)      : ceil(log2(n)), the tree depth for n operands
//   nw(n_in, lvl) : number of partial words held by tree level lvl,
//                   ceil(n_in / 2^(lvl+1))
// -----------------------------------------------------------------------------
package and_pkg;

   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = 1;
      while (v < n) begin
         v = v * 2;
         r = r + 1;
      end
      return r;
   endfunction

   function automatic int nw(input int n_in, input int lvl);
      return (n_in + (1 << (lvl + 1)) - 1) >> (lvl + 1);
   endfunction

endpackage

// File: rtl/and_tree_level.sv
// -----------------------------------------------------------------------------
// and_tree_level
// One registered level of the AND reduction tree. Words (2k, 2k+1) are ANDed
// into output word k; an odd trailing word passes through unchanged. The valid
// bit and nand flag travel alongside the data. All state advances only on en.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   en                  pipeline advance
//   in_valid, in_nand   valid / invert flag from the previous level
//   in_data             N_WORDS_IN partial words
//   out_valid, out_nand registered valid / invert flag
//   out_data            N_WORDS_OUT registered partial words
// -----------------------------------------------------------------------------
module and_tree_level
   import and_pkg::*;
#(
   parameter int N_WORDS_IN  = 2,
   parameter int DATA_W      = 1,
   localparam int N_WORDS_OUT = (N_WORDS_IN + 1) / 2
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  en,
   input  logic                                  in_valid,
   input  logic                                  in_nand,
   input  logic [N_WORDS_IN-1:0][DATA_W-1:0]     in_data,
   output logic                                  out_valid,
   output logic                                  out_nand,
   output logic [N_WORDS_OUT-1:0][DATA_W-1:0]    out_data
);

   logic [N_WORDS_OUT-1:0][DATA_W-1:0] pair_and;

   for (genvar k = 0; k < N_WORDS_OUT; k++) begin : g_pair
      if (2 * k + 1 < N_WORDS_IN) begin : g_and
         assign pair_and[k] = in_data[2*k] & in_data[2*k+1];
      end else begin : g_pass
         // unpaired word: equivalent to ANDing with all-ones
         assign pair_and[k] = in_data[2*k];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_nand  <= 1'b0;
         out_data  <= '0;
      end else if (en) begin
         // data loads even on bubbles; it is only meaningful with valid set
         out_valid <= in_valid;
         out_nand  <= in_nand;
         out_data  <= pair_and;
      end
   end

endmodule

// File: rtl/and_reduce_pipe.sv
// -----------------------------------------------------------------------------
// and_reduce_pipe
// Pipelined bitwise AND/NAND reduction of N_IN operands of DATA_W bits.
// Binary tree of D = clog2(N_IN) registered levels; latency D cycles,
// one word per cycle, valid/ready flow control with a global stall.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   in_valid     operand vector valid
//   in_ready     block accepts in_data this cycle (= pipeline enable)
//   in_data      operand k at [k*DATA_W +: DATA_W]
//   in_nand      invert the final result for this vector
//   out_valid    result valid
//   out_ready    consumer accepts result
//   out_data     reduction result
// -----------------------------------------------------------------------------
module and_reduce_pipe
   import and_pkg::*;
#(
   parameter int N_IN   = 3,
   parameter int DATA_W = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [N_IN*DATA_W-1:0]   in_data,
   input  logic                     in_nand,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_W-1:0]        out_data
);

   localparam int D = clog2(N_IN);

   logic                          en;
   logic [N_IN-1:0][DATA_W-1:0]   operands;

   // Whole pipe moves together: a held output freezes every level, so
   // in_ready depends only on out_ready and registered state.
   assign en       = !out_valid | out_ready;
   assign in_ready = en;
   assign operands = in_data;

   for (genvar l = 0; l < D; l++) begin : g_lvl
      localparam int NWI = (l == 0) ? N_IN : nw(N_IN, l - 1);
      localparam int NWO = nw(N_IN, l);

      logic [NWI-1:0][DATA_W-1:0] d_in;
      logic                       v_in;
      logic                       f_in;
      logic [NWO-1:0][DATA_W-1:0] d_out;
      logic                       v_out;
      logic                       f_out;

      if (l == 0) begin : g_src
         assign d_in = operands;
         assign v_in = in_valid;
         assign f_in = in_nand;
      end else begin : g_src
         assign d_in = g_lvl[l-1].d_out;
         assign v_in = g_lvl[l-1].v_out;
         assign f_in = g_lvl[l-1].f_out;
      end

      and_tree_level #(
         .N_WORDS_IN (NWI),
         .DATA_W     (DATA_W)
      ) u_lvl (
         .clk       (clk),
         .rst_n     (rst_n),
         .en        (en),
         .in_valid  (v_in),
         .in_nand   (f_in),
         .in_data   (d_in),
         .out_valid (v_out),
         .out_nand  (f_out),
         .out_data  (d_out)
      );
   end

   // XOR sits after the last register: out_data changes only on an edge or
   // reset, and reset clears the flag so out_data reads 0.
   assign out_valid = g_lvl[D-1].v_out;
   assign out_data  = g_lvl[D-1].d_out[0] ^ {DATA_W{g_lvl[D-1].f_out}};

endmodule

// File: tb/tb_and_reduce_pipe.sv
module tb_and_reduce_pipe;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // N_IN=3, DATA_W=1 (D=2)
   logic v3, r3, n3, ov3, or3;
   logic [2:0] d3;
   logic [0:0] od3;
   // N_IN=8, DATA_W=8 (D=3)
   logic v8, r8, n8, ov8, or8;
   logic [63:0] d8;
   logic [7:0]  od8;
   // N_IN=4, DATA_W=4 (D=2)
   logic v4, r4, n4, ov4, or4;
   logic [15:0] d4;
   logic [3:0]  od4;
   // N_IN=5, DATA_W=4 (D=3)
   logic v5, r5, n5, ov5, or5;
   logic [19:0] d5;
   logic [3:0]  od5;

   and_reduce_pipe #(.N_IN(3), .DATA_W(1)) u3 (
      .clk(clk), .rst_n(rst_n), .in_valid(v3), .in_ready(r3), .in_data(d3),
      .in_nand(n3), .out_valid(ov3), .out_ready(or3), .out_data(od3));
   and_reduce_pipe #(.N_IN(8), .DATA_W(8)) u8 (
      .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(r8), .in_data(d8),
      .in_nand(n8), .out_valid(ov8), .out_ready(or8), .out_data(od8));
   and_reduce_pipe #(.N_IN(4), .DATA_W(4)) u4 (
      .clk(clk), .rst_n(rst_n), .in_valid(v4), .in_ready(r4), .in_data(d4),
      .in_nand(n4), .out_valid(ov4), .out_ready(or4), .out_data(od4));
   and_reduce_pipe #(.N_IN(5), .DATA_W(4)) u5 (
      .clk(clk), .rst_n(rst_n), .in_valid(v5), .in_ready(r5), .in_data(d5),
      .in_nand(n5), .out_valid(ov5), .out_ready(or5), .out_data(od5));

   task automatic test_reset();
      #2;
      n_cmp++; if (ov3 !== 1'b0)  begin n_err++; $display("FAIL reset_ov3 got %0b want 0", ov3); end
      n_cmp++; if (od3 !== 1'b0)  begin n_err++; $display("FAIL reset_od3 got %0h want 0", od3); end
      n_cmp++; if (r3 !== 1'b1)   begin n_err++; $display("FAIL reset_r3 got %0b want 1", r3); end
      n_cmp++; if (ov8 !== 1'b0)  begin n_err++; $display("FAIL reset_ov8 got %0b want 0", ov8); end
      n_cmp++; if (od8 !== 8'h00) begin n_err++; $display("FAIL reset_od8 got %0h want 0", od8); end
      n_cmp++; if (r8 !== 1'b1)   begin n_err++; $display("FAIL reset_r8 got %0b want 1", r8); end
      n_cmp++; if (ov4 !== 1'b0)  begin n_err++; $display("FAIL reset_ov4 got %0b want 0", ov4); end
      n_cmp++; if (od4 !== 4'h0)  begin n_err++; $display("FAIL reset_od4 got %0h want 0", od4); end
      n_cmp++; if (ov5 !== 1'b0)  begin n_err++; $display("FAIL reset_ov5 got %0b want 0", ov5); end
      n_cmp++; if (od5 !== 4'h0)  begin n_err++; $display("FAIL reset_od5 got %0h want 0", od5); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++; if (ov8 !== 1'b0) begin n_err++; $display("FAIL post_reset_ov8 got %0b want 0", ov8); end
      n_cmp++; if (r4 !== 1'b1)  begin n_err++; $display("FAIL post_reset_r4 got %0b want 1", r4); end
   endtask

   // all 8 combinations streamed back-to-back, result 2 cycles later
   task automatic test_stream3();
      logic exp_d;
      for (int s = 0; s < 11; s++) begin
         @(posedge clk); #1;
         if (s < 8) begin v3 = 1'b1; d3 = s[2:0]; end
         else begin v3 = 1'b0; d3 = 3'b000; end
         @(negedge clk);
         n_cmp++; if (r3 !== 1'b1) begin n_err++; $display("FAIL stream3_ready s=%0d got %0b want 1", s, r3); end
         if (s >= 2 && s < 10) begin
            exp_d = (s == 9);
            n_cmp++; if (ov3 !== 1'b1) begin n_err++; $display("FAIL stream3_valid s=%0d got %0b want 1", s, ov3); end
            n_cmp++; if (od3 !== exp_d) begin n_err++; $display("FAIL stream3_data s=%0d got %0b want %0b", s, od3, exp_d); end
         end else begin
            n_cmp++; if (ov3 !== 1'b0) begin n_err++; $display("FAIL stream3_idle s=%0d got %0b want 0", s, ov3); end
         end
      end
      v3 = 1'b0;
   endtask

   // 8 operands, operand 5 = F0, AND then NAND
   task automatic test_and8();
      logic exp_v;
      for (int s = 0; s < 7; s++) begin
         @(posedge clk); #1;
         if (s < 2) begin
            v8 = 1'b1;
            d8 = {64{1'b1}};
            d8[47:40] = 8'hF0;
            n8 = (s == 1);
         end else begin
            v8 = 1'b0; n8 = 1'b0; d8 = '0;
         end
         @(negedge clk);
         exp_v = (s == 3 || s == 4);
         n_cmp++; if (ov8 !== exp_v) begin n_err++; $display("FAIL and8_valid s=%0d got %0b want %0b", s, ov8, exp_v); end
         if (s == 3) begin
            n_cmp++; if (od8 !== 8'hF0) begin n_err++; $display("FAIL and8_and got %0h want f0", od8); end
         end
         if (s == 4) begin
            n_cmp++; if (od8 !== 8'h0F) begin n_err++; $display("FAIL and8_nand got %0h want 0f", od8); end
         end
      end
   endtask

   // out_ready low for 5 cycles after first result
   task automatic test_backpressure();
      logic [3:0] wv [4];
      int pi, ci, stalls;
      logic in_fire;
      wv[0] = 4'h9; wv[1] = 4'h6; wv[2] = 4'hA; wv[3] = 4'h5;
      pi = 0; ci = 0; stalls = 0; in_fire = 1'b0;
      for (int s = 0; s < 20; s++) begin
         @(posedge clk); #1;
         if (in_fire) pi++;
         if (pi < 4) begin
            v4 = 1'b1;
            d4 = 16'hFFFF;
            d4[(pi%4)*4 +: 4] = wv[pi];
         end else begin
            v4 = 1'b0; d4 = '0;
         end
         or4 = !(s >= 2 && s <= 6);
         @(negedge clk);
         if (ov4 && !or4) begin
            stalls++;
            n_cmp++; if (r4 !== 1'b0) begin n_err++; $display("FAIL bp_stall_ready s=%0d got %0b want 0", s, r4); end
            n_cmp++; if (od4 !== wv[ci]) begin n_err++; $display("FAIL bp_stall_hold s=%0d got %0h want %0h", s, od4, wv[ci]); end
         end else if (ov4 && or4) begin
            n_cmp++; if (ci >= 4 || od4 !== wv[ci % 4]) begin n_err++; $display("FAIL bp_order idx=%0d got %0h want %0h", ci, od4, wv[ci % 4]); end
            ci++;
         end
         in_fire = v4 && r4;
      end
      or4 = 1'b1;
      n_cmp++; if (ci !== 4) begin n_err++; $display("FAIL bp_count got %0d want 4", ci); end
      n_cmp++; if (stalls !== 5) begin n_err++; $display("FAIL bp_stalls got %0d want 5", stalls); end
   endtask

   // odd operand count: the unpaired word must survive each level
   task automatic test_odd5();
      logic [19:0] vec [3];
      logic [3:0]  exp_d [3];
      vec[0] = 20'h7FFFF; exp_d[0] = 4'h7;
      vec[1] = 20'hFFFF7; exp_d[1] = 4'h7;
      vec[2] = 20'hFF3FF; exp_d[2] = 4'h3;
      for (int s = 0; s < 7; s++) begin
         @(posedge clk); #1;
         if (s < 3) begin v5 = 1'b1; d5 = vec[s]; end
         else begin v5 = 1'b0; d5 = '0; end
         @(negedge clk);
         if (s >= 3 && s < 6) begin
            n_cmp++; if (ov5 !== 1'b1) begin n_err++; $display("FAIL odd5_valid s=%0d got %0b want 1", s, ov5); end
            n_cmp++; if (od5 !== exp_d[s-3]) begin n_err++; $display("FAIL odd5_data s=%0d got %0h want %0h", s, od5, exp_d[s-3]); end
         end else begin
            n_cmp++; if (ov5 !== 1'b0) begin n_err++; $display("FAIL odd5_idle s=%0d got %0b want 0", s, ov5); end
         end
      end
   endtask

   // async reset with three words in flight
   task automatic test_reset_mid();
      for (int s = 0; s < 3; s++) begin
         @(posedge clk); #1;
         v8 = 1'b1; d8 = {64{1'b1}}; n8 = 1'b0;
      end
      @(posedge clk); #1;
      v8 = 1'b0; d8 = '0;
      #2;
      n_cmp++; if (ov8 !== 1'b1 || od8 !== 8'hFF) begin n_err++; $display("FAIL rstmid_pre got v=%0b d=%0h want v=1 d=ff", ov8, od8); end
      rst_n = 1'b0;
      #1;
      n_cmp++; if (ov8 !== 1'b0) begin n_err++; $display("FAIL rstmid_valid got %0b want 0", ov8); end
      n_cmp++; if (od8 !== 8'h00) begin n_err++; $display("FAIL rstmid_data got %0h want 0", od8); end
      @(negedge clk);
      rst_n = 1'b1;
      n_cmp++; if (r8 !== 1'b1) begin n_err++; $display("FAIL rstmid_ready got %0b want 1", r8); end
      for (int s = 0; s < 6; s++) begin
         @(negedge clk);
         n_cmp++; if (ov8 !== 1'b0) begin n_err++; $display("FAIL rstmid_stale s=%0d got %0b want 0", s, ov8); end
      end
   endtask

   // alternating bubbles keep their spacing through the pipe
   task automatic test_bubbles();
      logic       exp_v;
      logic [7:0] exp_d;
      for (int s = 0; s < 13; s++) begin
         @(posedge clk); #1;
         v8 = (s < 8) && (s % 2 == 0);
         d8 = {64{1'b1}};
         d8[7:0] = 8'hF0 | s[7:0];
         n8 = 1'b0;
         @(negedge clk);
         exp_v = (s >= 3) && (s < 11) && ((s - 3) % 2 == 0);
         exp_d = 8'hF0 | 8'(s - 3);
         n_cmp++; if (r8 !== 1'b1) begin n_err++; $display("FAIL bub_ready s=%0d got %0b want 1", s, r8); end
         n_cmp++; if (ov8 !== exp_v) begin n_err++; $display("FAIL bub_valid s=%0d got %0b want %0b", s, ov8, exp_v); end
         if (exp_v) begin
            n_cmp++; if (od8 !== exp_d) begin n_err++; $display("FAIL bub_data s=%0d got %0h want %0h", s, od8, exp_d); end
         end
      end
      v8 = 1'b0;
   endtask

   initial begin
      v3 = 0; n3 = 0; or3 = 1; d3 = '0;
      v8 = 0; n8 = 0; or8 = 1; d8 = '0;
      v4 = 0; n4 = 0; or4 = 1; d4 = '0;
      v5 = 0; n5 = 0; or5 = 1; d5 = '0;
      test_reset();
      test_stream3();
      test_and8();
      test_backpressure();
      test_odd5();
      test_reset_mid();
      test_bubbles();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

endmodule
